// File: rtl/mmio_uart_tx.sv
// MMIO 8N1 UART transmitter: TXDATA store enqueues a byte, STATUS load returns {overflow, full, busy}.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic [31:0] rd,
   output logic        sel,
   output logic        txd
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shreg;
   logic          r_ovf;

   logic          w_wr_data;
   logic          w_wr_stat;
   logic          w_bit_end;
   logic          w_pop;
   logic          w_push;
   logic          w_full;
   logic          w_empty;
   logic          w_busy;
   logic [7:0]    w_q_dat;
   logic          w_unused;

   assign sel       = (dataadr[31:3] == BASE_ADDR[31:3]);
   assign w_wr_data = memwrite && sel && !dataadr[2];
   assign w_wr_stat = memwrite && sel &&  dataadr[2];
   assign w_bit_end = (r_cnt == '0);
   // The pop frees a slot on the same edge, so a write to a full queue is still accepted.
   assign w_pop     = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end));
   assign w_push    = w_wr_data && (!w_full || w_pop);
   assign w_busy    = (r_state != S_IDLE) || !w_empty;
   assign rd        = (sel && dataadr[2]) ? {29'b0, r_ovf, w_full, w_busy} : 32'b0;

`ifdef UART_TX_FIFO_EN
   localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;

   assign w_full   = (r_count == (PW+1)'(FIFO_DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_q_dat  = r_mem[r_rptr];
   assign w_unused = ^{writedata[31:8], dataadr[1:0]};

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= writedata[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
`else
   logic [7:0] r_hold;
   logic       r_hold_vld;

   assign w_full   = r_hold_vld;
   assign w_empty  = !r_hold_vld;
   assign w_q_dat  = r_hold;
   assign w_unused = ^{writedata[31:8], dataadr[1:0], (FIFO_DEPTH == 0)};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold     <= 8'h00;
         r_hold_vld <= 1'b0;
      end else if (w_push) begin
         r_hold     <= writedata[7:0];
         r_hold_vld <= 1'b1;
      end else if (w_pop) begin
         r_hold_vld <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (w_wr_stat) begin
         r_ovf <= 1'b0;
      end else if (w_wr_data && w_full && !w_pop) begin
         r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (!w_empty) w_next = S_START;
         S_START: if (w_bit_end) w_next = S_DATA;
         S_DATA:  if (w_bit_end && r_bit == 3'd7) w_next = S_STOP;
         S_STOP:  if (w_bit_end) w_next = w_empty ? S_IDLE : S_START;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      case (r_state)
         S_START: txd = 1'b0;
         S_DATA:  txd = r_shreg[0];
         default: txd = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_bit   <= 3'd0;
         r_shreg <= 8'h00;
      end else if (w_pop) begin
         r_cnt   <= CNT_LOAD;
         r_bit   <= 3'd0;
         r_shreg <= w_q_dat;
      end else if (r_state != S_IDLE) begin
         if (w_bit_end) begin
            r_cnt <= CNT_LOAD;
            if (r_state == S_DATA) begin
               r_shreg <= {1'b0, r_shreg[7:1]};
               r_bit   <= r_bit + 3'd1;
            end
         end else begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4; queue tests follow UART_TX_FIFO_EN.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'hFFFF_FF00;
   localparam int          CPB  = 4;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [31:0] rd;
   logic        sel;
   logic        txd;

   int n_assert = 0;
   int n_fail   = 0;

   mmio_uart_tx #(
      .BASE_ADDR   (BASE),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .memwrite (memwrite),
      .dataadr  (dataadr),
      .writedata(writedata),
      .rd       (rd),
      .sel      (sel),
      .txd      (txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwrite  = 1'b1;
      dataadr   = a;
      writedata = d;
   endtask

   task automatic idle_at(input logic [31:0] a);
      memwrite  = 1'b0;
      dataadr   = a;
      writedata = 32'h0;
   endtask

   // Called just after a negedge; sample j is taken in the cycle after edge E1+j.
   task automatic chk_frame(input logic [7:0] b, input int j0, input int j1, input string tag);
      logic e;
      for (int j = j0; j < j1; j++) begin
         #1;
         if (j < CPB)            e = 1'b0;
         else if (j < 9 * CPB)   e = b[(j - CPB) / CPB];
         else                    e = 1'b1;
         chk(tag, {31'b0, txd}, {31'b0, e});
         @(negedge clk);
      end
   endtask

   initial begin
      reset     = 1'b1;
      memwrite  = 1'b0;
      dataadr   = 32'h0;
      writedata = 32'h0;
      repeat (3) @(negedge clk);

      // reset state and address decode
      reset = 1'b0;
      idle_at(BASE + 32'd4);
      #1;
      chk("rst_rd", rd, 32'h0);
      chk("rst_sel", {31'b0, sel}, 32'd1);
      chk("rst_txd", {31'b0, txd}, 32'd1);
      dataadr = BASE + 32'd8;
      #1;
      chk("b8_sel", {31'b0, sel}, 32'd0);
      chk("b8_rd", rd, 32'h0);
      dataadr = BASE - 32'd4;
      #1;
      chk("bm4_sel", {31'b0, sel}, 32'd0);

      // single frame of 0x55
      @(negedge clk);
      store(BASE, 32'h0000_0155);
      #1;
      chk("f1_txd_e0", {31'b0, txd}, 32'd1);
      @(negedge clk);
      idle_at(BASE);
      #1;
      chk("txdata_rd", rd, 32'h0);
      chk("txdata_sel", {31'b0, sel}, 32'd1);
      chk("f1_txd_pre", {31'b0, txd}, 32'd1);
      dataadr = BASE + 32'd5;
      #1;
`ifdef UART_TX_FIFO_EN
      chk("f1_stat_queued", rd, 32'h1);
`else
      chk("f1_stat_queued", rd, 32'h3);
`endif
      @(negedge clk);
      chk_frame(8'h55, 0, 40, "frame_55");
      #1;
      chk("f1_stat_done", rd, 32'h0);
      chk("f1_txd_idle", {31'b0, txd}, 32'd1);

`ifdef UART_TX_FIFO_EN
      // five back-to-back stores: all fit since the first pops at E1
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         store(BASE, 32'hABCD_0011 + i);
         @(negedge clk);
      end
      idle_at(BASE + 32'd4);
      #1;
      chk("f5_stat_full", rd, 32'h3);
      chk_frame(8'h11, 3, 40, "f5_b11");
      chk_frame(8'h12, 0, 40, "f5_b12");
      chk_frame(8'h13, 0, 40, "f5_b13");
      chk_frame(8'h14, 0, 40, "f5_b14");
      chk_frame(8'h15, 0, 40, "f5_b15");
      #1;
      chk("f5_stat_done", rd, 32'h0);

      // six stores: the sixth is dropped and flags overflow
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         store(BASE, 32'h11 + i);
         @(negedge clk);
      end
      idle_at(BASE + 32'd4);
      #1;
      chk("f6_stat_ovf", rd, 32'h7);
      store(BASE + 32'd4, 32'hFFFF_FFFF);
      @(negedge clk);
      idle_at(BASE + 32'd4);
      #1;
      chk("f6_stat_clr", rd, 32'h3);
      chk_frame(8'h11, 5, 40, "f6_b11");
      chk_frame(8'h12, 0, 40, "f6_b12");
      chk_frame(8'h13, 0, 40, "f6_b13");
      chk_frame(8'h14, 0, 40, "f6_b14");
      chk_frame(8'h15, 0, 40, "f6_b15");
      for (int i = 0; i < 12; i++) begin
         #1;
         chk("f6_no_sixth", {31'b0, txd}, 32'd1);
         @(negedge clk);
      end
      #1;
      chk("f6_stat_done", rd, 32'h0);
`else
      // three stores into the holding register: the third is dropped
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         store(BASE, 32'h11 + i);
         @(negedge clk);
      end
      idle_at(BASE + 32'd4);
      #1;
      chk("h3_stat_ovf", rd, 32'h7);
      chk_frame(8'h11, 1, 40, "h3_b11");
      chk_frame(8'h12, 0, 40, "h3_b12");
      for (int i = 0; i < 12; i++) begin
         #1;
         chk("h3_no_third", {31'b0, txd}, 32'd1);
         @(negedge clk);
      end
      #1;
      chk("h3_stat_sticky", rd, 32'h4);
      store(BASE + 32'd4, 32'h0);
      @(negedge clk);
      idle_at(BASE + 32'd4);
      #1;
      chk("h3_stat_clr", rd, 32'h0);
`endif

      // reset during data bit 3 aborts the frame and drops the queued byte
      @(negedge clk);
      store(BASE, 32'h0000_00A5);
      @(negedge clk);
      store(BASE, 32'h0000_003C);
      @(negedge clk);
      idle_at(BASE + 32'd4);
      chk_frame(8'hA5, 0, 16, "rst_frame");
      #1;
      chk("rst_bit3", {31'b0, txd}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_txd_hi", {31'b0, txd}, 32'd1);
      chk("rst_stat", rd, 32'h0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         chk("rst_quiet", {31'b0, txd}, 32'd1);
      end
      chk("rst_stat_end", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the data-memory bus of the single-cycle `mips` core. It sits downstream of the core alongside `DataMemory` and observes the same `memwrite`/`dataadr`/`writedata` store stream. Stores that hit its address window enqueue bytes, which are serialised onto `txd` as 8N1 frames. Loads from its window return a status word, which the top level muxes into `readdata`.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hFFFF_FF00: word-aligned base of the 2-register window.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, default 4: power of two, ≥2; used only when `UART_TX_FIFO_EN` is defined.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `memwrite` input 1: store strobe from the core.
- `dataadr` input 32: store/load byte address (ALU output).
- `writedata` input 32: store data.
- `rd` output 32: status read data, combinational from `dataadr`.
- `sel` output 1: combinational; 1 when `dataadr[31:3] == BASE_ADDR[31:3]`.
- `txd` output 1: serial line, idle high.

## Operation
- Register map:
  - TXDATA at `BASE_ADDR+0`, write-only. A store enqueues `writedata[7:0]`; upper bits are ignored.
  - STATUS at `BASE_ADDR+4`. Reads return `{29'b0, overflow, full, busy}`. A store of any value clears `overflow`.
- `rd` is 0 when `sel`=0 or `dataadr[2]`=0.
- `busy` = 1 when the FSM is not IDLE or the queue is non-empty.
- `full` = 1 when the queue is full.
- A write to TXDATA while full with no pop on the same edge is dropped and sets the sticky `overflow` bit.
- If full and a pop occur on the same edge, the write is accepted.
- `dataadr[1:0]` is ignored.
- FSM states:
  - IDLE, `txd`=1.
  - START, `txd`=0.
  - DATA, `txd`=`shreg[0]`, 8 bits LSB first.
  - STOP, `txd`=1.
- Each non-IDLE bit lasts exactly `CLKS_PER_BIT` cycles, timed by a down-counter; the DATA bit index is a 3-bit counter.
- Transitions:
  - IDLE→START when the queue is non-empty; the byte is popped into `shreg` on that edge.
  - START→DATA after one bit time.
  - DATA→STOP after bit 7.
  - STOP→START directly (pop on that edge, no idle gap) if the queue is non-empty at the end of the stop bit, otherwise STOP→IDLE.
- Reset values: `txd`=1, FSM=IDLE, queue empty, `overflow`=0, counters=0. `rd`/`sel` follow `dataadr` combinationally.
- Reset asserted mid-frame: the frame is aborted and `txd` is 1 from the reset edge onward. Queued bytes are discarded.

## Timing
- Store to TXDATA sampled at edge E0: the byte is in the queue after E0. If IDLE, the pop happens at E1 and `txd` falls at E1.
- Frame length is 10×`CLKS_PER_BIT` cycles. Data bit k starts at E1 + (k+1)×`CLKS_PER_BIT`.
- Back-to-back queued bytes produce contiguous frames with no idle cycles.
- `full` and `overflow` update on the edge of the causing store and are visible to a load in the next cycle.
- Write and overflow-clear do not conflict because they use different addresses.
- If a dropped write and a STATUS store coincide, that is impossible; only one store occurs per cycle.

## Configuration
- `UART_TX_FIFO_EN` defined: the queue is a circular FIFO of `FIFO_DEPTH` entries with wrapping read/write pointers and a count of width log2(`FIFO_DEPTH`)+1. `full` when count==`FIFO_DEPTH`.
- `UART_TX_FIFO_EN` undefined: the queue is a single holding register plus valid bit, so `full`=valid. The second store to an idle transmitter is accepted only after the first byte is popped (E1). `FIFO_DEPTH` is ignored.

## Test plan
- Reset, then STATUS load at BASE+4 → `rd`=0, `sel`=1, `txd`=1. Load at BASE+8 → `sel`=0, `rd`=0.
- `CLKS_PER_BIT`=4, store 32'h0000_0155 to BASE+0 → `txd` low at E1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1. `busy` deasserts after 40 cycles.
- FIFO build, 5 stores 8'h11..8'h15 on consecutive cycles while idle → all 5 bytes emitted as contiguous frames; no `overflow` (the first is popped at E1).
- FIFO build, 6 consecutive stores → 5 accepted, `full`=1 then `overflow`=1. Store to BASE+4 → `overflow`=0.
- Non-FIFO build, 3 consecutive stores → 2 bytes sent, `overflow`=1.
- Assert `reset` for 1 cycle during DATA bit 3 → `txd`=1 from the reset edge, STATUS=0, no further frame.
